// File: rtl/dsram_arb.sv
// dsram_arb: two-master arbiter for data SRAM sram1 (m0 = core LSU, m1 = DMA/debug loader).
// Optional m1 burst lock is compiled in when ARB_LOCK_EN is defined.
module dsram_arb #(
  parameter int AW         = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_req,
  input  logic [AW+1:0] m0_a,
  input  logic [3:0]    m0_we,
  input  logic [31:0]   m0_wd,
  input  logic [3:0]    m0_re,
  output logic          m0_gnt,
  output logic [31:0]   m0_rd,
  output logic          m0_rvld,

  input  logic          m1_req,
  input  logic [AW+1:0] m1_a,
  input  logic [3:0]    m1_we,
  input  logic [31:0]   m1_wd,
  input  logic [3:0]    m1_re,
  output logic          m1_gnt,
  output logic [31:0]   m1_rd,
  output logic          m1_rvld,
  input  logic          m1_lock,

  output logic [AW-1:0] sram_a,
  output logic [3:0]    sram_we,
  output logic [31:0]   sram_wd,
  output logic [3:0]    sram_re,
  input  logic [31:0]   sram_rd
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_M0   = 2'd1;
  localparam logic [1:0] OWN_M1   = 2'd2;

  logic [3:0]    starve_cnt;
  logic [1:0]    rd_owner;
  logic [AW-1:0] a_hold;
  logic [31:0]   wd_hold;
  logic [31:0]   m0_rd_q;
  logic [31:0]   m1_rd_q;

  logic          in_lock;
  logic          m1_win;
  logic          any_gnt;
  logic          is_write;
  logic          is_read;
  logic [AW+1:0] sel_a;
  logic [3:0]    sel_we;
  logic [3:0]    sel_re;
  logic [31:0]   sel_wd;

`ifdef ARB_LOCK_EN
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_LOCK1 = 1'b1;

  logic [0:0] state;
  logic       unused_addr_bits;

  // The lock only holds while m1_lock stays high, so dropping it releases the SRAM in the same cycle.
  assign in_lock = (state == ST_LOCK1) && m1_lock;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (m1_lock && (m1_gnt || (state == ST_LOCK1))) begin
      state <= ST_LOCK1;
    end else begin
      state <= ST_IDLE;
    end
  end

  assign unused_addr_bits = ^{m0_a[1:0], m1_a[1:0]};
`else
  logic unused_inputs;

  assign in_lock       = 1'b0;
  assign unused_inputs = ^{m1_lock, m0_a[1:0], m1_a[1:0]};
`endif

  always_comb begin
    m1_win = m1_req && (in_lock || (starve_cnt == STARVE_LIM) || !m0_req);
    m1_gnt = !rst && m1_win;
    m0_gnt = !rst && m0_req && !m1_win && !in_lock;
    any_gnt = m0_gnt || m1_gnt;
  end

  always_comb begin
    sel_a  = m1_gnt ? m1_a  : m0_a;
    sel_we = m1_gnt ? m1_we : m0_we;
    sel_re = m1_gnt ? m1_re : m0_re;
    sel_wd = m1_gnt ? m1_wd : m0_wd;
    is_write = |sel_we;
    is_read  = !is_write && (|sel_re);
  end

  // Address and write data hold their last values on idle cycles so the SRAM pins stay quiet.
  always_comb begin
    sram_a  = any_gnt ? sel_a[AW+1:2] : a_hold;
    sram_wd = any_gnt ? sel_wd : wd_hold;
    sram_we = any_gnt ? sel_we : 4'h0;
    sram_re = (any_gnt && !is_write) ? sel_re : 4'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_hold  <= '0;
      wd_hold <= '0;
    end else if (any_gnt) begin
      a_hold  <= sel_a[AW+1:2];
      wd_hold <= sel_wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (in_lock) begin
      starve_cnt <= starve_cnt;
    end else if (!m1_req || m1_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // The SRAM answers one cycle after the command, so remember who asked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_owner <= OWN_NONE;
    end else if (any_gnt && is_read) begin
      rd_owner <= m1_gnt ? OWN_M1 : OWN_M0;
    end else begin
      rd_owner <= OWN_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_rd_q <= '0;
      m1_rd_q <= '0;
    end else begin
      if (rd_owner == OWN_M0) m0_rd_q <= sram_rd;
      if (rd_owner == OWN_M1) m1_rd_q <= sram_rd;
    end
  end

  always_comb begin
    m0_rvld = (rd_owner == OWN_M0);
    m1_rvld = (rd_owner == OWN_M1);
    m0_rd   = m0_rvld ? sram_rd : m0_rd_q;
    m1_rd   = m1_rvld ? sram_rd : m1_rd_q;
  end

endmodule

// File: tb/tb_dsram_arb.sv
// tb_dsram_arb: self-checking bench for dsram_arb with a behavioural SRAM and a read scoreboard.
// Expectations for the m1 lock follow ARB_LOCK_EN when it is defined for the build.
module tb_dsram_arb;

  localparam int AW         = 14;
  localparam int STARVE_MAX = 4;
  localparam int DEPTH      = 1 << AW;

`ifdef ARB_LOCK_EN
  localparam bit LOCK_BUILD = 1'b1;
`else
  localparam bit LOCK_BUILD = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          m0_req, m1_req, m1_lock;
  logic [AW+1:0] m0_a, m1_a;
  logic [3:0]    m0_we, m1_we, m0_re, m1_re;
  logic [31:0]   m0_wd, m1_wd;
  logic          m0_gnt, m1_gnt, m0_rvld, m1_rvld;
  logic [31:0]   m0_rd, m1_rd;
  logic [AW-1:0] sram_a;
  logic [3:0]    sram_we, sram_re;
  logic [31:0]   sram_wd, sram_rd;

  typedef struct packed {
    logic        is_m1;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem    [DEPTH];
  logic [31:0] shadow [DEPTH];
  logic [31:0] exp_m0_hold;
  int          total;
  int          bad;

  dsram_arb #(.AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_a(m0_a), .m0_we(m0_we), .m0_wd(m0_wd), .m0_re(m0_re),
    .m0_gnt(m0_gnt), .m0_rd(m0_rd), .m0_rvld(m0_rvld),
    .m1_req(m1_req), .m1_a(m1_a), .m1_we(m1_we), .m1_wd(m1_wd), .m1_re(m1_re),
    .m1_gnt(m1_gnt), .m1_rd(m1_rd), .m1_rvld(m1_rvld), .m1_lock(m1_lock),
    .sram_a(sram_a), .sram_we(sram_we), .sram_wd(sram_wd), .sram_re(sram_re),
    .sram_rd(sram_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: writes land in the command cycle, reads return on the next edge.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (sram_we[b]) mem[sram_a][8*b +: 8] <= sram_wd[8*b +: 8];
    if (|sram_re) sram_rd <= mem[sram_a];
  end

  task automatic drive_m0(input logic req, input logic [AW+1:0] a, input logic [3:0] we,
                          input logic [31:0] wd, input logic [3:0] re);
    m0_req = req; m0_a = a; m0_we = we; m0_wd = wd; m0_re = re;
  endtask

  task automatic drive_m1(input logic req, input logic [AW+1:0] a, input logic [3:0] we,
                          input logic [31:0] wd, input logic [3:0] re);
    m1_req = req; m1_a = a; m1_we = we; m1_wd = wd; m1_re = re;
  endtask

  task automatic shadow_write(input logic [AW+1:0] a, input logic [3:0] we, input logic [31:0] wd);
    for (int b = 0; b < 4; b++)
      if (we[b]) shadow[a[AW+1:2]][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m1_lock = 1'b0;
    drive_m0(1'b1, 16'h0010, 4'h0, 32'h0, 4'hF);
    drive_m1(1'b1, 16'h0020, 4'h0, 32'h0, 4'hF);
    for (int c = 0; c < 2; c++) begin
      sample();
      total++;
      if ({m0_gnt, m1_gnt, m0_rvld, m1_rvld} !== 4'b0000) begin
        bad++; $display("[TB] FAIL reset_gnt_rvld: got %b expected 0000", {m0_gnt, m1_gnt, m0_rvld, m1_rvld});
      end
      total++;
      if ({sram_we, sram_re} !== 8'h00) begin
        bad++; $display("[TB] FAIL reset_we_re: got %h expected 00", {sram_we, sram_re});
      end
      total++;
      if ({sram_a, sram_wd, m0_rd, m1_rd} !== '0) begin
        bad++; $display("[TB] FAIL reset_data: sram_a=%h sram_wd=%h m0_rd=%h m1_rd=%h expected all 0",
                        sram_a, sram_wd, m0_rd, m1_rd);
      end
      next_cycle();
    end
    rst = 1'b0;
    drive_m0(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
    drive_m1(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
    sample();
    total++;
    if (dut.starve_cnt !== 4'd0) begin
      bad++; $display("[TB] FAIL reset_starve_cnt: got %0d expected 0", dut.starve_cnt);
    end
    next_cycle();
  endtask

  task automatic test_write_read();
    exp_t e;
    drive_m0(1'b1, 16'h0010, 4'hF, 32'hDEADBEEF, 4'h0);
    sample();
    total++;
    if ({m0_gnt, m1_gnt, sram_a, sram_we, sram_re, sram_wd} !== {2'b10, 14'h004, 4'hF, 4'h0, 32'hDEADBEEF}) begin
      bad++; $display("[TB] FAIL wr_cmd: gnt=%b a=%h we=%h re=%h wd=%h expected 10 004 f 0 deadbeef",
                      {m0_gnt, m1_gnt}, sram_a, sram_we, sram_re, sram_wd);
    end
    shadow_write(16'h0010, 4'hF, 32'hDEADBEEF);
    next_cycle();

    drive_m0(1'b1, 16'h0010, 4'h0, 32'h0, 4'hF);
    sample();
    total++;
    if ({m0_gnt, sram_a, sram_we, sram_re, m0_rvld} !== {1'b1, 14'h004, 4'h0, 4'hF, 1'b0}) begin
      bad++; $display("[TB] FAIL rd_cmd: gnt=%b a=%h we=%h re=%h rvld=%b expected 1 004 0 f 0",
                      m0_gnt, sram_a, sram_we, sram_re, m0_rvld);
    end
    sb.push_back('{is_m1: 1'b0, data: shadow[14'h004]});
    next_cycle();

    drive_m0(1'b0, 16'hFFFC, 4'hF, 32'h12345678, 4'hF);
    sample();
    e = sb.pop_front();
    total++;
    if ({m0_rvld, m1_rvld} !== 2'b10) begin
      bad++; $display("[TB] FAIL rd_rvld: got %b expected 10", {m0_rvld, m1_rvld});
    end
    total++;
    if (m0_rd !== e.data) begin
      bad++; $display("[TB] FAIL rd_data: got %h expected %h", m0_rd, e.data);
    end
    total++;
    if ({sram_a, sram_we, sram_re} !== {14'h004, 4'h0, 4'h0}) begin
      bad++; $display("[TB] FAIL idle_hold: a=%h we=%h re=%h expected 004 0 0", sram_a, sram_we, sram_re);
    end
    exp_m0_hold = e.data;
    next_cycle();

    sample();
    total++;
    if ({m0_rvld, m0_rd} !== {1'b0, exp_m0_hold}) begin
      bad++; $display("[TB] FAIL rd_hold: rvld=%b rd=%h expected 0 %h", m0_rvld, m0_rd, exp_m0_hold);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    int   bcnt = 0;
    logic w1;
    drive_m0(1'b1, 16'h0100, 4'h0, 32'h0, 4'h0);
    drive_m1(1'b1, 16'h0200, 4'h0, 32'h0, 4'h0);
    for (int c = 0; c < 10; c++) begin
      sample();
      w1 = (bcnt == STARVE_MAX);
      total++;
      if ({m0_gnt, m1_gnt} !== {!w1, w1}) begin
        bad++; $display("[TB] FAIL starve_gnt c%0d: got %b expected %b", c, {m0_gnt, m1_gnt}, {!w1, w1});
      end
      total++;
      if (dut.starve_cnt !== 4'(bcnt)) begin
        bad++; $display("[TB] FAIL starve_cnt c%0d: got %0d expected %0d", c, dut.starve_cnt, bcnt);
      end
      total++;
      if ({m0_rvld, m1_rvld, sram_re} !== 6'b0) begin
        bad++; $display("[TB] FAIL starve_noop c%0d: rvld=%b re=%h expected 00 0", c, {m0_rvld, m1_rvld}, sram_re);
      end
      bcnt = w1 ? 0 : ((bcnt < STARVE_MAX) ? bcnt + 1 : bcnt);
      next_cycle();
    end
    drive_m0(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
    sample();
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      bad++; $display("[TB] FAIL m1_alone: got %b expected 01", {m0_gnt, m1_gnt});
    end
    next_cycle();
    drive_m1(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
    next_cycle();
  endtask

  task automatic test_byte_write();
    exp_t e;
    drive_m1(1'b1, 16'h0020, 4'hF, 32'h11223344, 4'h0);
    sample();
    total++;
    if ({m1_gnt, sram_a, sram_we} !== {1'b1, 14'h008, 4'hF}) begin
      bad++; $display("[TB] FAIL bw_full: gnt=%b a=%h we=%h expected 1 008 f", m1_gnt, sram_a, sram_we);
    end
    shadow_write(16'h0020, 4'hF, 32'h11223344);
    next_cycle();

    drive_m1(1'b1, 16'h0022, 4'b0100, 32'h00AB0000, 4'h0);
    sample();
    total++;
    if ({m1_gnt, sram_a, sram_we, sram_wd} !== {1'b1, 14'h008, 4'b0100, 32'h00AB0000}) begin
      bad++; $display("[TB] FAIL bw_byte: gnt=%b a=%h we=%h wd=%h expected 1 008 4 00ab0000",
                      m1_gnt, sram_a, sram_we, sram_wd);
    end
    shadow_write(16'h0022, 4'b0100, 32'h00AB0000);
    next_cycle();

    drive_m1(1'b1, 16'h0020, 4'h0, 32'h0, 4'hF);
    sample();
    total++;
    if ({m1_gnt, sram_re} !== {1'b1, 4'hF}) begin
      bad++; $display("[TB] FAIL bw_rd_cmd: gnt=%b re=%h expected 1 f", m1_gnt, sram_re);
    end
    sb.push_back('{is_m1: 1'b1, data: shadow[14'h008]});
    next_cycle();

    drive_m1(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
    sample();
    e = sb.pop_front();
    total++;
    if ({m0_rvld, m1_rvld, m1_rd} !== {2'b01, e.data}) begin
      bad++; $display("[TB] FAIL bw_readback: rvld=%b rd=%h expected 01 %h", {m0_rvld, m1_rvld}, m1_rd, e.data);
    end
    total++;
    if (m0_rd !== exp_m0_hold) begin
      bad++; $display("[TB] FAIL bw_m0_hold: got %h expected %h", m0_rd, exp_m0_hold);
    end
    next_cycle();
  endtask

  task automatic test_collision();
    drive_m0(1'b1, 16'h0030, 4'h1, 32'h00000055, 4'hF);
    sample();
    total++;
    if ({m0_gnt, sram_we, sram_re} !== {1'b1, 4'h1, 4'h0}) begin
      bad++; $display("[TB] FAIL coll_cmd: gnt=%b we=%h re=%h expected 1 1 0", m0_gnt, sram_we, sram_re);
    end
    shadow_write(16'h0030, 4'h1, 32'h00000055);
    next_cycle();

    drive_m0(1'b1, 16'h0040, 4'h0, 32'h0, 4'h0);
    sample();
    total++;
    if (m0_rvld !== 1'b0) begin
      bad++; $display("[TB] FAIL coll_rvld: got %b expected 0", m0_rvld);
    end
    total++;
    if ({m0_gnt, sram_a, sram_we, sram_re} !== {1'b1, 14'h010, 4'h0, 4'h0}) begin
      bad++; $display("[TB] FAIL noop_cmd: gnt=%b a=%h we=%h re=%h expected 1 010 0 0",
                      m0_gnt, sram_a, sram_we, sram_re);
    end
    next_cycle();

    drive_m0(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
    sample();
    total++;
    if ({m0_rvld, m1_rvld} !== 2'b00) begin
      bad++; $display("[TB] FAIL noop_rvld: got %b expected 00", {m0_rvld, m1_rvld});
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    bit             tbl_m1 [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [AW+1:0]  tbl_a  [5] = '{16'h0010, 16'h0030, 16'h0020, 16'h0010, 16'h0030};
    exp_t           e;
    logic [31:0]    got;
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) begin
        if (tbl_m1[i]) begin
          drive_m1(1'b1, tbl_a[i], 4'h0, 32'h0, 4'hF);
          drive_m0(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
        end else begin
          drive_m0(1'b1, tbl_a[i], 4'h0, 32'h0, 4'hF);
          drive_m1(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
        end
      end else begin
        drive_m0(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
        drive_m1(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
      end
      sample();
      if (i < 5) begin
        total++;
        if ({m0_gnt, m1_gnt, sram_a, sram_re} !== {!tbl_m1[i], tbl_m1[i], tbl_a[i][AW+1:2], 4'hF}) begin
          bad++; $display("[TB] FAIL b2b_cmd %0d: gnt=%b a=%h re=%h", i, {m0_gnt, m1_gnt}, sram_a, sram_re);
        end
      end
      if (i > 0) begin
        e = sb.pop_front();
        got = e.is_m1 ? m1_rd : m0_rd;
        total++;
        if ({m0_rvld, m1_rvld} !== {!e.is_m1, e.is_m1}) begin
          bad++; $display("[TB] FAIL b2b_rvld %0d: got %b expected %b", i, {m0_rvld, m1_rvld}, {!e.is_m1, e.is_m1});
        end
        total++;
        if (got !== e.data) begin
          bad++; $display("[TB] FAIL b2b_data %0d: got %h expected %h", i, got, e.data);
        end
        if (!e.is_m1) exp_m0_hold = e.data;
      end
      if (i < 5) sb.push_back('{is_m1: tbl_m1[i], data: shadow[tbl_a[i][AW+1:2]]});
      next_cycle();
    end
  endtask

  task automatic test_lock();
    drive_m0(1'b0, 16'h0050, 4'h0, 32'h0, 4'h0);
    drive_m1(1'b1, 16'h0060, 4'h0, 32'h0, 4'h0);
    m1_lock = 1'b1;
    sample();
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      bad++; $display("[TB] FAIL lock_first: got %b expected 01", {m0_gnt, m1_gnt});
    end
    next_cycle();
    m0_req = 1'b1;
    for (int c = 0; c < 2; c++) begin
      sample();
      total++;
      if ({m0_gnt, m1_gnt} !== {!LOCK_BUILD, LOCK_BUILD}) begin
        bad++; $display("[TB] FAIL lock_hold %0d: got %b expected %b", c, {m0_gnt, m1_gnt}, {!LOCK_BUILD, LOCK_BUILD});
      end
      next_cycle();
    end
    m1_lock = 1'b0;
    sample();
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      bad++; $display("[TB] FAIL lock_release: got %b expected 10", {m0_gnt, m1_gnt});
    end
    next_cycle();
    drive_m0(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
    drive_m1(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    drive_m0(1'b1, 16'h0030, 4'h0, 32'h0, 4'hF);
    sample();
    total++;
    if ({m0_gnt, sram_re} !== {1'b1, 4'hF}) begin
      bad++; $display("[TB] FAIL mid_rd_cmd: gnt=%b re=%h expected 1 f", m0_gnt, sram_re);
    end
    next_cycle();
    rst = 1'b1;
    drive_m0(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
    #1;
    total++;
    if ({m0_rvld, m1_rvld} !== 2'b00) begin
      bad++; $display("[TB] FAIL mid_rd_async: got %b expected 00", {m0_rvld, m1_rvld});
    end
    next_cycle();
    rst = 1'b0;
    sample();
    total++;
    if ({m0_rvld, m1_rvld, m0_rd} !== {2'b00, 32'h0}) begin
      bad++; $display("[TB] FAIL mid_rd_after: rvld=%b rd=%h expected 00 0", {m0_rvld, m1_rvld}, m0_rd);
    end
    total++;
    if (sb.size() !== 0) begin
      bad++; $display("[TB] FAIL sb_empty: got %0d expected 0", sb.size());
    end
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    exp_m0_hold = 32'h0;
    sram_rd = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 32'h0;
      shadow[i] = 32'h0;
    end
    rst = 1'b1;
    m1_lock = 1'b0;
    drive_m0(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);
    drive_m1(1'b0, 16'h0, 4'h0, 32'h0, 4'h0);

    test_reset();
    test_write_read();
    test_starvation();
    test_byte_write();
    test_collision();
    test_back_to_back();
    test_lock();
    test_reset_mid_read();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
